// File: rtl/xform_arb.sv
// xform_arb: lets two clients (A, B) share one transform device.
// One transaction is in flight at a time. The result is routed back to the
// client that issued it. Ties go to the client that was not served last.
module xform_arb #(
  parameter int N = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_wr_a,
  input  logic         i_wr_b,
  input  logic [N-1:0] i_data_a,
  input  logic [N-1:0] i_data_b,
  output logic         o_bsy_a,
  output logic         o_bsy_b,
  input  logic         i_rd_a,
  input  logic         i_rd_b,
  output logic [N-1:0] o_data_a,
  output logic [N-1:0] o_data_b,
  output logic         o_rdy_a,
  output logic         o_rdy_b,
  output logic         o_dev_wr,
  output logic [N-1:0] o_dev_data,
  input  logic         i_dev_bsy,
  output logic         o_dev_rd,
  input  logic [N-1:0] i_dev_data,
  input  logic         i_dev_rdy
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, HOLD} state_t;

  state_t       state;
  logic [N-1:0] req_buf;
  logic [N-1:0] result;
  logic         owner;        // 0 = A, 1 = B
  logic         last_served;  // 0 = A, 1 = B
  logic         gnt_a;
  logic         gnt_b;
  logic         rd_owner;

  // Combinational grant in IDLE: sole requester wins; on a tie the client not served last wins
  always_comb begin
    gnt_a = '0;
    gnt_b = '0;
    if (state == IDLE) begin
      if (i_wr_a && i_wr_b) begin
        gnt_a = last_served;
        gnt_b = ~last_served;
      end else begin
        gnt_a = i_wr_a;
        gnt_b = i_wr_b;
      end
    end
  end

  assign o_bsy_a    = ~gnt_a;
  assign o_bsy_b    = ~gnt_b;
  assign rd_owner   = (i_rd_a && o_rdy_a) || (i_rd_b && o_rdy_b);
  assign o_dev_rd   = (state == WAIT) && i_dev_rdy;
  assign o_dev_data = req_buf;
  assign o_data_a   = result;
  assign o_data_b   = result;

  // Transaction FSM. o_dev_wr and o_rdy_x are registered alongside the state:
  // each one is set on entry to the state that needs it and cleared on exit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      req_buf     <= '0;
      result      <= '0;
      owner       <= '0;
      last_served <= '1;
      o_dev_wr    <= '0;
      o_rdy_a     <= '0;
      o_rdy_b     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_a || gnt_b) begin
            req_buf     <= gnt_b ? i_data_b : i_data_a;
            owner       <= gnt_b;
            last_served <= gnt_b;
            o_dev_wr    <= '1;
            state       <= SEND;
          end
        end
        SEND: begin
          if (!i_dev_bsy) begin
            o_dev_wr <= '0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (i_dev_rdy) begin
            result  <= i_dev_data;
            o_rdy_a <= ~owner;
            o_rdy_b <= owner;
            state   <= HOLD;
          end
        end
        HOLD: begin
          if (rd_owner) begin
            o_rdy_a <= '0;
            o_rdy_b <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xform_arb.sv
// tb_xform_arb: directed scenarios plus a randomized run against a
// transaction-level reference model of the arbiter and a case-swap device.
module tb_xform_arb;

  localparam int N = 8;

  logic         i_clk;
  logic         i_rst_n;
  logic         i_wr_a, i_wr_b;
  logic [N-1:0] i_data_a, i_data_b;
  logic         o_bsy_a, o_bsy_b;
  logic         i_rd_a, i_rd_b;
  logic [N-1:0] o_data_a, o_data_b;
  logic         o_rdy_a, o_rdy_b;
  logic         o_dev_wr;
  logic [N-1:0] o_dev_data;
  logic         i_dev_bsy;
  logic         o_dev_rd;
  logic [N-1:0] i_dev_data;
  logic         i_dev_rdy;

  xform_arb #(.N(N)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_wr_a(i_wr_a), .i_wr_b(i_wr_b),
    .i_data_a(i_data_a), .i_data_b(i_data_b),
    .o_bsy_a(o_bsy_a), .o_bsy_b(o_bsy_b),
    .i_rd_a(i_rd_a), .i_rd_b(i_rd_b),
    .o_data_a(o_data_a), .o_data_b(o_data_b),
    .o_rdy_a(o_rdy_a), .o_rdy_b(o_rdy_b),
    .o_dev_wr(o_dev_wr), .o_dev_data(o_dev_data), .i_dev_bsy(i_dev_bsy),
    .o_dev_rd(o_dev_rd), .i_dev_data(i_dev_data), .i_dev_rdy(i_dev_rdy)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int n_checks;
  int n_pass;

  // Case-swap device model: accepts one word, answers after dev_k cycles
  bit           dev_have;
  int           dev_cnt;
  logic [N-1:0] dev_held;
  int           dev_k;
  int           dev_bsy_left;
  bit           dev_rand_bsy;
  int           dev_wr_count;

  function automatic logic [N-1:0] swapcase(input logic [N-1:0] d);
    if (d >= 8'h61 && d <= 8'h7a) return d - 8'h20;
    if (d >= 8'h41 && d <= 8'h5a) return d + 8'h20;
    return d;
  endfunction

  task automatic drive_dev();
    i_dev_rdy  = dev_have && (dev_cnt == 0);
    i_dev_data = i_dev_rdy ? swapcase(dev_held) : N'($urandom);
    if (dev_have || dev_bsy_left > 0) i_dev_bsy = 1'b1;
    else i_dev_bsy = dev_rand_bsy ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  task automatic settle();
    drive_dev();
    #1;
  endtask

  // Advance one clock: device reacts to the handshakes visible before the edge
  task automatic clk_edge();
    bit           wr_fire, rd_fire, bsy_hit;
    logic [N-1:0] wdata;
    wr_fire = (o_dev_wr === 1'b1) && !i_dev_bsy;
    rd_fire = (o_dev_rd === 1'b1);
    bsy_hit = (o_dev_wr === 1'b1) && i_dev_bsy && dev_bsy_left > 0;
    wdata   = o_dev_data;
    @(posedge i_clk);
    if (bsy_hit) dev_bsy_left--;
    if (rd_fire) dev_have = 1'b0;
    else if (wr_fire && !dev_have) begin
      dev_have = 1'b1; dev_held = wdata; dev_cnt = dev_k - 1; dev_wr_count++;
    end else if (dev_have && dev_cnt > 0) dev_cnt--;
    @(negedge i_clk);
  endtask

  task automatic wait_rdy(input bit cb, input int limit, output bit ok);
    int w = 0;
    settle();
    while (((cb ? o_rdy_b : o_rdy_a) !== 1'b1) && w < limit) begin
      clk_edge(); settle(); w++;
    end
    ok = ((cb ? o_rdy_b : o_rdy_a) === 1'b1);
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    i_wr_a = 1'b1; i_wr_b = 1'b1; i_rd_a = 1'b1; i_rd_b = 1'b1;
    i_data_a = 8'h55; i_data_b = 8'h66;
    i_dev_bsy = 1'b0; i_dev_rdy = 1'b1; i_dev_data = 8'hff;
    repeat (2) @(negedge i_clk);
    #1;
    n_checks++; if (o_rdy_a !== 1'b0) $display("FAIL reset_rdy_a got %b want 0", o_rdy_a); else n_pass++;
    n_checks++; if (o_rdy_b !== 1'b0) $display("FAIL reset_rdy_b got %b want 0", o_rdy_b); else n_pass++;
    n_checks++; if (o_dev_wr !== 1'b0) $display("FAIL reset_dev_wr got %b want 0", o_dev_wr); else n_pass++;
    n_checks++; if (o_dev_rd !== 1'b0) $display("FAIL reset_dev_rd got %b want 0", o_dev_rd); else n_pass++;
    n_checks++; if (o_data_a !== 8'h00) $display("FAIL reset_data_a got %h want 00", o_data_a); else n_pass++;
    n_checks++; if (o_data_b !== 8'h00) $display("FAIL reset_data_b got %h want 00", o_data_b); else n_pass++;
    n_checks++; if (o_dev_data !== 8'h00) $display("FAIL reset_dev_data got %h want 00", o_dev_data); else n_pass++;
    i_wr_a = 1'b0; i_wr_b = 1'b0; i_rd_a = 1'b0; i_rd_b = 1'b0;
    dev_have = 1'b0;
    i_rst_n = 1'b1;
    settle();
    n_checks++; if (o_bsy_a !== 1'b1 || o_bsy_b !== 1'b1) $display("FAIL idle_nogrant_bsy got %b%b want 11", o_bsy_a, o_bsy_b); else n_pass++;
    i_wr_b = 1'b1; #1;
    n_checks++; if (o_bsy_a !== 1'b1 || o_bsy_b !== 1'b0) $display("FAIL idle_only_b_bsy got %b%b want 10", o_bsy_a, o_bsy_b); else n_pass++;
    i_wr_b = 1'b0; i_wr_a = 1'b1; #1;
    n_checks++; if (o_bsy_a !== 1'b0 || o_bsy_b !== 1'b1) $display("FAIL idle_only_a_bsy got %b%b want 01", o_bsy_a, o_bsy_b); else n_pass++;
    i_wr_a = 1'b0; #1;
    clk_edge();
  endtask

  task automatic test_simultaneous();
    bit ok;
    int bad = 0;
    int w = 0;
    dev_k = 2;
    i_wr_a = 1'b1; i_data_a = 8'h41; i_wr_b = 1'b1; i_data_b = 8'h62;
    settle();
    n_checks++; if (o_bsy_a !== 1'b0 || o_bsy_b !== 1'b1) $display("FAIL sim_tie_bsy got %b%b want 01", o_bsy_a, o_bsy_b); else n_pass++;
    clk_edge();
    i_wr_a = 1'b0;
    settle();
    while (o_rdy_a !== 1'b1 && w < 40) begin
      if (o_bsy_b !== 1'b1 || o_rdy_b !== 1'b0) bad++;
      clk_edge(); settle(); w++;
    end
    n_checks++; if (bad != 0) $display("FAIL sim_b_held_busy got %0d bad cycles want 0", bad); else n_pass++;
    n_checks++; if (o_rdy_a !== 1'b1) $display("FAIL sim_a_rdy got %b want 1", o_rdy_a); else n_pass++;
    n_checks++; if (o_data_a !== 8'h61) $display("FAIL sim_a_data got %h want 61", o_data_a); else n_pass++;
    n_checks++; if (o_rdy_b !== 1'b0) $display("FAIL sim_b_not_rdy got %b want 0", o_rdy_b); else n_pass++;
    i_rd_a = 1'b1; #1;
    n_checks++; if (o_bsy_b !== 1'b1) $display("FAIL sim_no_grant_on_hold_exit got %b want 1", o_bsy_b); else n_pass++;
    clk_edge();
    i_rd_a = 1'b0;
    settle();
    n_checks++; if (o_rdy_a !== 1'b0) $display("FAIL sim_a_rdy_cleared got %b want 0", o_rdy_a); else n_pass++;
    n_checks++; if (o_bsy_b !== 1'b0) $display("FAIL sim_b_granted got %b want 0", o_bsy_b); else n_pass++;
    clk_edge();
    i_wr_b = 1'b0;
    wait_rdy(1'b1, 40, ok);
    n_checks++; if (!ok) $display("FAIL sim_b_rdy_timeout got 0 want 1"); else n_pass++;
    n_checks++; if (o_data_b !== 8'h42) $display("FAIL sim_b_data got %h want 42", o_data_b); else n_pass++;
    n_checks++; if (o_rdy_a !== 1'b0) $display("FAIL sim_a_not_rdy got %b want 0", o_rdy_a); else n_pass++;
    i_rd_b = 1'b1; clk_edge(); i_rd_b = 1'b0;
  endtask

  task automatic test_fairness();
    bit who;
    int w;
    dev_k = 1;
    i_wr_a = 1'b1; i_data_a = 8'h61; i_wr_b = 1'b1; i_data_b = 8'h42;
    for (int t = 0; t < 6; t++) begin
      w = 0;
      settle();
      while (o_rdy_a !== 1'b1 && o_rdy_b !== 1'b1 && w < 40) begin
        clk_edge(); settle(); w++;
      end
      who = (o_rdy_b === 1'b1);
      n_checks++; if (o_rdy_a !== 1'b1 && o_rdy_b !== 1'b1) $display("FAIL fair_timeout txn %0d got none want rdy", t); else n_pass++;
      n_checks++; if (who !== 1'(t % 2)) $display("FAIL fair_order txn %0d got %s want %s", t, who ? "B" : "A", (t % 2) ? "B" : "A"); else n_pass++;
      n_checks++; if (o_data_a !== (who ? 8'h62 : 8'h41)) $display("FAIL fair_data txn %0d got %h want %h", t, o_data_a, who ? 8'h62 : 8'h41); else n_pass++;
      if (who) i_rd_b = 1'b1; else i_rd_a = 1'b1;
      clk_edge();
      i_rd_a = 1'b0; i_rd_b = 1'b0;
    end
    i_wr_a = 1'b0; i_wr_b = 1'b0;
  endtask

  task automatic test_single_a();
    int w0;
    dev_k = 3;
    w0 = dev_wr_count;
    i_wr_a = 1'b1; i_data_a = 8'h61;
    settle();
    n_checks++; if (o_bsy_a !== 1'b0) $display("FAIL single_grant got %b want 0", o_bsy_a); else n_pass++;
    clk_edge();
    i_wr_a = 1'b0;
    settle();
    n_checks++; if (o_dev_wr !== 1'b1 || o_dev_data !== 8'h61) $display("FAIL single_send got wr=%b data=%h want wr=1 data=61", o_dev_wr, o_dev_data); else n_pass++;
    for (int e = 1; e <= dev_k + 1; e++) begin
      clk_edge(); settle();
      n_checks++; if (o_rdy_a !== 1'(e == dev_k + 1)) $display("FAIL latency_rdy edge %0d got %b want %b", e, o_rdy_a, e == dev_k + 1); else n_pass++;
      n_checks++; if (o_dev_rd !== 1'(e == dev_k)) $display("FAIL latency_dev_rd edge %0d got %b want %b", e, o_dev_rd, e == dev_k); else n_pass++;
    end
    n_checks++; if (o_data_a !== 8'h41) $display("FAIL single_data got %h want 41", o_data_a); else n_pass++;
    n_checks++; if (o_rdy_b !== 1'b0) $display("FAIL single_rdy_b got %b want 0", o_rdy_b); else n_pass++;
    n_checks++; if (dev_wr_count - w0 != 1) $display("FAIL single_dev_writes got %0d want 1", dev_wr_count - w0); else n_pass++;
    i_rd_a = 1'b1; clk_edge(); i_rd_a = 1'b0;
    settle();
    n_checks++; if (o_rdy_a !== 1'b0) $display("FAIL single_rdy_cleared got %b want 0", o_rdy_a); else n_pass++;
    i_wr_b = 1'b1; #1;
    n_checks++; if (o_bsy_b !== 1'b0) $display("FAIL single_back_idle got %b want 0", o_bsy_b); else n_pass++;
    i_wr_b = 1'b0; #1;
    clk_edge();
  endtask

  task automatic test_dev_busy();
    bit ok;
    int w0;
    dev_k = 2; dev_bsy_left = 5;
    w0 = dev_wr_count;
    i_wr_a = 1'b1; i_data_a = 8'h7a;
    settle(); clk_edge();
    i_wr_a = 1'b0;
    for (int c = 0; c < 5; c++) begin
      settle();
      n_checks++; if (o_dev_wr !== 1'b1 || o_dev_data !== 8'h7a) $display("FAIL busy_hold cyc %0d got wr=%b data=%h want wr=1 data=7a", c, o_dev_wr, o_dev_data); else n_pass++;
      clk_edge();
    end
    n_checks++; if (dev_wr_count != w0) $display("FAIL busy_no_write got %0d want 0", dev_wr_count - w0); else n_pass++;
    settle();
    n_checks++; if (o_dev_wr !== 1'b1 || o_dev_data !== 8'h7a) $display("FAIL busy_release got wr=%b data=%h want wr=1 data=7a", o_dev_wr, o_dev_data); else n_pass++;
    clk_edge(); settle();
    n_checks++; if (o_dev_wr !== 1'b0) $display("FAIL busy_wr_drop got %b want 0", o_dev_wr); else n_pass++;
    wait_rdy(1'b0, 40, ok);
    n_checks++; if (!ok || o_data_a !== 8'h5a) $display("FAIL busy_result got rdy=%b data=%h want rdy=1 data=5a", ok, o_data_a); else n_pass++;
    n_checks++; if (dev_wr_count - w0 != 1) $display("FAIL busy_one_write got %0d want 1", dev_wr_count - w0); else n_pass++;
    i_rd_a = 1'b1; clk_edge(); i_rd_a = 1'b0;
  endtask

  task automatic test_hold_delay();
    bit ok;
    dev_k = 1;
    i_wr_a = 1'b1; i_data_a = 8'h4d;
    settle(); clk_edge();
    i_wr_a = 1'b0;
    wait_rdy(1'b0, 40, ok);
    n_checks++; if (!ok) $display("FAIL hold_rdy_timeout got 0 want 1"); else n_pass++;
    i_wr_b = 1'b1; i_data_b = 8'h39;
    for (int c = 0; c < 4; c++) begin
      i_rd_b = 1'(c % 2);
      settle();
      n_checks++; if (o_rdy_a !== 1'b1) $display("FAIL hold_rdy_a cyc %0d got %b want 1", c, o_rdy_a); else n_pass++;
      n_checks++; if (o_data_a !== 8'h6d || o_data_b !== 8'h6d) $display("FAIL hold_data cyc %0d got %h/%h want 6d/6d", c, o_data_a, o_data_b); else n_pass++;
      n_checks++; if (o_rdy_b !== 1'b0 || o_bsy_b !== 1'b1) $display("FAIL hold_b_ignored cyc %0d got rdy=%b bsy=%b want rdy=0 bsy=1", c, o_rdy_b, o_bsy_b); else n_pass++;
      clk_edge();
    end
    i_rd_b = 1'b0; i_wr_b = 1'b0; i_rd_a = 1'b1;
    clk_edge();
    i_rd_a = 1'b0;
    settle();
    n_checks++; if (o_rdy_a !== 1'b0) $display("FAIL hold_release got %b want 0", o_rdy_a); else n_pass++;
    clk_edge();
  endtask

  task automatic test_reset_mid();
    bit ok;
    dev_k = 6;
    i_wr_a = 1'b1; i_data_a = 8'h61;
    settle(); clk_edge();
    i_wr_a = 1'b0;
    settle(); clk_edge();
    settle(); clk_edge();
    settle();
    n_checks++; if (o_rdy_a !== 1'b0 || o_dev_wr !== 1'b0) $display("FAIL mid_in_wait got rdy=%b wr=%b want 0/0", o_rdy_a, o_dev_wr); else n_pass++;
    i_rst_n = 1'b0;
    #1;
    n_checks++; if (o_rdy_a !== 1'b0 || o_rdy_b !== 1'b0) $display("FAIL mid_rst_rdy got %b%b want 00", o_rdy_a, o_rdy_b); else n_pass++;
    n_checks++; if (o_dev_data !== 8'h00 || o_data_a !== 8'h00) $display("FAIL mid_rst_regs got %h/%h want 00/00", o_dev_data, o_data_a); else n_pass++;
    dev_have = 1'b0;
    clk_edge();
    i_rst_n = 1'b1;
    settle();
    n_checks++; if (o_rdy_a !== 1'b0 || o_dev_rd !== 1'b0) $display("FAIL mid_abandoned got rdy=%b rd=%b want 0/0", o_rdy_a, o_dev_rd); else n_pass++;
    i_wr_b = 1'b1; i_data_b = 8'h62;
    #1;
    n_checks++; if (o_bsy_b !== 1'b0) $display("FAIL mid_b_grant got %b want 0", o_bsy_b); else n_pass++;
    clk_edge();
    i_wr_b = 1'b0;
    wait_rdy(1'b1, 40, ok);
    n_checks++; if (!ok || o_data_b !== 8'h42 || o_rdy_a !== 1'b0) $display("FAIL mid_b_result got rdy=%b data=%h rdy_a=%b want 1/42/0", ok, o_data_b, o_rdy_a); else n_pass++;
    i_rd_b = 1'b1; clk_edge(); i_rd_b = 1'b0;
  endtask

  // Random traffic checked against a transaction-level model:
  // txn_open/sent/done record how far the current transaction has got.
  task automatic test_random();
    int           left_a = 25, left_b = 25, cyc = 0;
    bit           wait_a = 0, wait_b = 0;
    logic [N-1:0] pend_a, pend_b, t_data;
    bit           t_open = 0, t_sent = 0, t_done = 0, t_own = 0, m_last = 1;
    bit           win_v, win_b, wr_fire, rd_fire, rd_ok;
    pend_a = N'($urandom); pend_b = N'($urandom); t_data = '0;
    i_wr_a = 0; i_wr_b = 0; i_rd_a = 0; i_rd_b = 0;
    i_rst_n = 1'b0; dev_have = 1'b0; dev_rand_bsy = 1'b1;
    #1; clk_edge();
    i_rst_n = 1'b1;
    while ((left_a > 0 || left_b > 0 || t_open) && cyc < 4000) begin
      dev_k    = $urandom_range(1, 4);
      i_wr_a   = !wait_a && left_a > 0 && ($urandom_range(0, 3) != 0);
      i_wr_b   = !wait_b && left_b > 0 && ($urandom_range(0, 3) != 0);
      i_data_a = pend_a; i_data_b = pend_b;
      i_rd_a   = wait_a ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
      i_rd_b   = wait_b ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
      settle();
      win_v = 0; win_b = 0;
      if (!t_open && (i_wr_a || i_wr_b)) begin
        win_v = 1;
        win_b = (i_wr_a && i_wr_b) ? !m_last : i_wr_b;
      end
      n_checks++; if (o_bsy_a !== !(win_v && !win_b)) $display("FAIL rnd_bsy_a cyc %0d got %b want %b", cyc, o_bsy_a, !(win_v && !win_b)); else n_pass++;
      n_checks++; if (o_bsy_b !== !(win_v && win_b)) $display("FAIL rnd_bsy_b cyc %0d got %b want %b", cyc, o_bsy_b, !(win_v && win_b)); else n_pass++;
      n_checks++; if (o_rdy_a !== (t_done && !t_own) || o_rdy_b !== (t_done && t_own)) $display("FAIL rnd_rdy cyc %0d got %b%b want %b%b", cyc, o_rdy_a, o_rdy_b, t_done && !t_own, t_done && t_own); else n_pass++;
      if (t_done) begin
        n_checks++; if (o_data_a !== swapcase(t_data) || o_data_b !== swapcase(t_data)) $display("FAIL rnd_result cyc %0d got %h/%h want %h", cyc, o_data_a, o_data_b, swapcase(t_data)); else n_pass++;
      end
      n_checks++; if (o_dev_wr !== (t_open && !t_sent)) $display("FAIL rnd_dev_wr cyc %0d got %b want %b", cyc, o_dev_wr, t_open && !t_sent); else n_pass++;
      if (t_open && !t_sent) begin
        n_checks++; if (o_dev_data !== t_data) $display("FAIL rnd_dev_data cyc %0d got %h want %h", cyc, o_dev_data, t_data); else n_pass++;
      end
      n_checks++; if (o_dev_rd !== (t_open && t_sent && !t_done && i_dev_rdy)) $display("FAIL rnd_dev_rd cyc %0d got %b want %b", cyc, o_dev_rd, t_open && t_sent && !t_done && i_dev_rdy); else n_pass++;
      wr_fire = t_open && !t_sent && !i_dev_bsy;
      rd_fire = t_open && t_sent && !t_done && i_dev_rdy;
      rd_ok   = t_done && (t_own ? i_rd_b : i_rd_a);
      clk_edge();
      cyc++;
      if (rd_ok) begin
        t_open = 0; t_done = 0;
        if (t_own) wait_b = 0; else wait_a = 0;
      end else if (rd_fire) t_done = 1;
      else if (wr_fire) t_sent = 1;
      else if (win_v) begin
        t_open = 1; t_sent = 0; t_done = 0; t_own = win_b; m_last = win_b;
        if (win_b) begin t_data = pend_b; wait_b = 1; left_b--; pend_b = N'($urandom); end
        else begin t_data = pend_a; wait_a = 1; left_a--; pend_a = N'($urandom); end
      end
    end
    n_checks++; if (left_a != 0 || left_b != 0 || t_open) $display("FAIL rnd_completion got left=%0d/%0d open=%b want 0/0/0", left_a, left_b, t_open); else n_pass++;
    i_wr_a = 0; i_wr_b = 0; i_rd_a = 0; i_rd_b = 0; dev_rand_bsy = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    dev_have = 1'b0; dev_cnt = 0; dev_held = '0; dev_k = 1;
    dev_bsy_left = 0; dev_rand_bsy = 1'b0; dev_wr_count = 0;
    test_reset();
    test_simultaneous();
    test_fairness();
    test_single_a();
    test_dev_busy();
    test_hold_delay();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion (%0d/%0d so far)", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/xform_arb.md
XFORM_ARB -- requirements
Module: xform_arb

Interface
REQ-001 The module SHALL have parameter N, default 8, meaning data bus bit width for clients and device.
REQ-002 The module SHALL have port i_clk, input, 1, system clock; all state changes occur on its rising edge.
REQ-003 The module SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-004 The module SHALL have ports i_wr_a / i_wr_b, input, 1, write request from client A / B.
REQ-005 The module SHALL have ports i_data_a / i_data_b, input, N, write data from client A / B.
REQ-006 The module SHALL have ports o_bsy_a / o_bsy_b, output, 1, client A / B busy; a write is accepted only when i_wr_x && !o_bsy_x.
REQ-007 The module SHALL have ports i_rd_a / i_rd_b, input, 1, read request from client A / B.
REQ-008 The module SHALL have ports o_data_a / o_data_b, output, N, result data to client A / B.
REQ-009 The module SHALL have ports o_rdy_a / o_rdy_b, output, 1, result ready to client A / B; a read is accepted only when i_rd_x && o_rdy_x.
REQ-010 The module SHALL have ports o_dev_wr (output, 1), o_dev_data (output, N) and i_dev_bsy (input, 1), the write side of the shared transform device.
REQ-011 The module SHALL have ports o_dev_rd (output, 1), i_dev_data (input, N) and i_dev_rdy (input, 1), the read side of the shared transform device.

Function
REQ-012 The block SHALL share one transform device between two clients, one transaction in flight at a time, and route each result back to the client that issued it.
REQ-013 The FSM SHALL have states IDLE, SEND, WAIT and HOLD, plus registers: req buffer (N), result (N), owner (1) and last-served (1).
REQ-014 In IDLE, grant SHALL be combinational: the only requester if one; if both, the client not equal to last-served; if none, no grant.
REQ-015 In IDLE, o_bsy of the granted client SHALL be 0 and all other o_bsy SHALL be 1; outside IDLE both o_bsy SHALL be 1.
REQ-016 On an accepted client write, the block SHALL latch its data into the req buffer, set owner and last-served to that client, and enter SEND.
REQ-017 In SEND, o_dev_wr SHALL be 1 and o_dev_data SHALL equal the req buffer; when i_dev_bsy==0 the device write is accepted and the FSM SHALL enter WAIT.
REQ-018 In SEND with i_dev_bsy==1, o_dev_wr and o_dev_data SHALL be held unchanged, with no timeout.
REQ-019 In WAIT, o_dev_rd SHALL equal i_dev_rdy; when i_dev_rdy==1 the block SHALL latch i_dev_data into result and enter HOLD.
REQ-020 o_dev_rd SHALL be 0 in all states other than WAIT, and o_dev_wr SHALL be 0 in all states other than SEND.
REQ-021 In HOLD, the owner's o_rdy SHALL be 1, the non-owner's o_rdy SHALL be 0, and the owner's i_rd SHALL return the FSM to IDLE.
REQ-022 A new grant SHALL NOT be made in the cycle HOLD exits; the earliest new acceptance is the following IDLE cycle.
REQ-023 o_data_a and o_data_b SHALL both be driven from the result register and SHALL be stable whenever o_rdy of either client is 1.
REQ-024 Best-case latency SHALL be: client write accepted at edge 0, device write at edge 1, result latched at edge k+1 where k is the device response cycles, and o_rdy_owner high after edge k+1.
REQ-025 i_rd of the non-owner and i_wr of a non-granted client SHALL be ignored with no state change.
REQ-026 The arbiter SHALL be fair: a client continuously requesting SHALL be served within one transaction of the other client.

Reset
REQ-027 While i_rst_n==0, the FSM SHALL be in IDLE, last-served SHALL be B (so A wins the first tie), and req buffer, result and owner SHALL be 0.
REQ-028 During reset, all o_rdy, o_dev_wr and o_dev_rd SHALL be 0 and o_data_a/b and o_dev_data SHALL be 0.
REQ-029 Reset asserted mid-transaction SHALL abandon the transaction with no result delivered; resetting the device is the integrator's responsibility.

Verification
REQ-030 With a case-swap device, client A writing 8'h61 SHALL yield o_rdy_a=1 with o_data_a=8'h41, o_rdy_b=0, and return to IDLE after i_rd_a.
REQ-031 A and B writing simultaneously after reset (8'h41, 8'h62) SHALL serve A first (8'h61), then B (8'h42), with B held busy meanwhile.
REQ-032 Both clients requesting continuously for 6 transactions SHALL be granted in the order A,B,A,B,A,B.
REQ-033 i_dev_bsy held at 1 for 5 cycles in SEND SHALL keep o_dev_wr=1 with a stable o_dev_data, then accept exactly one device write.
REQ-034 Delaying i_rd_a for 4 cycles in HOLD SHALL keep o_rdy_a=1 and o_data_a stable, and SHALL ignore i_rd_b pulses and i_wr_b.
REQ-035 Asserting i_rst_n=0 in WAIT SHALL immediately return the FSM to IDLE with all o_rdy=0, and a subsequent write from B SHALL be accepted normally.
